operand_sel_pipe: RTL and testbench

Parametrised N-way operand selector with a registered, flow-controlled output stage. It is the successor to the combinational 2:1 32-bit mux and is used in the pipelined MIPS datapath for ALU-operand and forwarding selection where a stage boundary is required. It selects one of NUM_IN words, then registers the result behind a valid/ready handshake. A 2-entry skid buffer gives full throughput with a registered in_ready. A synchronous flush supports branch/hazard squash.

---
 rtl/operand_sel_pipe_skid_reg.sv | 85 ++++++++
 rtl/operand_sel_pipe.sv | 60 ++++++
 tb/tb_operand_sel_pipe.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/operand_sel_pipe_skid_reg.sv
// Two-entry valid/ready skid buffer: main register drives the outputs, the skid
// register catches the word that arrives while downstream stalls.
module skid_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] FULL1 = 2'b10;
  localparam logic [1:0] FULL2 = 2'b11;

  logic             main_v;
  logic             skid_v;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_d;
  logic             accept;
  logic             xmit;

  assign accept    = in_valid && in_ready;
  assign xmit      = main_v && out_ready;
  assign out_valid = main_v;
  assign out_data  = main_d;

  // in_ready is kept as a flop equal to !skid_v so upstream sees no combinational path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v   <= 1'b0;
      skid_v   <= 1'b0;
      in_ready <= 1'b1;
      main_d   <= '0;
    end else if (flush) begin
      main_v   <= 1'b0;
      skid_v   <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      case ({main_v, skid_v})
        EMPTY: begin
          if (accept) begin
            main_v <= 1'b1;
            main_d <= in_data;
          end
        end
        FULL1: begin
          if (accept && xmit) begin
            main_d <= in_data;
          end else if (accept) begin
            skid_v   <= 1'b1;
            in_ready <= 1'b0;
          end else if (xmit) begin
            main_v <= 1'b0;
          end
        end
        FULL2: begin
          if (xmit) begin
            main_d   <= skid_d;
            skid_v   <= 1'b0;
            in_ready <= 1'b1;
          end
        end
        default: begin
          main_v   <= 1'b0;
          skid_v   <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  // Skid data is only meaningful under skid_v, so it loads on every accept without reset
  always_ff @(posedge clk) begin
    if (accept) begin
      skid_d <= in_data;
    end
  end

endmodule

// File: rtl/operand_sel_pipe.sv
// N-way operand selector followed by a registered valid/ready stage with flush,
// flagging out-of-range selects with a one-cycle sel_err pulse.
module operand_sel_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  logic [WIDTH-1:0] word_p0;
  logic             sel_bad_p0;

  // Out-of-range selects fall through to word 0
  always_comb begin
    word_p0 = in_bus[WIDTH-1:0];
    for (int k = 1; k < NUM_IN; k++) begin
      if (int'(sel) == k) begin
        word_p0 = in_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  assign sel_bad_p0 = (int'(sel) >= NUM_IN);

  // ---- stage boundary: selected word enters the skid buffer ----
  skid_reg #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_data  (word_p0),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Pulse follows acceptance, not delivery, and is dropped for flushed words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= in_valid && in_ready && sel_bad_p0 && !flush;
    end
  end

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Directed bench for operand_sel_pipe: a 4-input and a 3-input instance side by side.
module tb_operand_sel_pipe;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;

  logic [127:0] bus4;
  logic [1:0]   sel4;
  logic         in_valid4, in_ready4, out_valid4, out_ready4, sel_err4;
  logic [31:0]  out_data4;

  logic [95:0]  bus3;
  logic [1:0]   sel3;
  logic         in_valid3, in_ready3, out_valid3, out_ready3, sel_err3;
  logic [31:0]  out_data3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  operand_sel_pipe #(.WIDTH(32), .NUM_IN(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_bus(bus4), .sel(sel4), .in_valid(in_valid4),
    .in_ready(in_ready4), .flush(flush), .out_data(out_data4), .out_valid(out_valid4),
    .out_ready(out_ready4), .sel_err(sel_err4)
  );

  operand_sel_pipe #(.WIDTH(32), .NUM_IN(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_bus(bus3), .sel(sel3), .in_valid(in_valid3),
    .in_ready(in_ready3), .flush(flush), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready3), .sel_err(sel_err3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string name, input logic [31:0] d, input logic v,
                      input logic r, input logic e);
    vectors++;
    if ((v && out_data4 !== d) || out_valid4 !== v || in_ready4 !== r || sel_err4 !== e) begin
      miscompares++;
      $display("FAIL %s: got data=%0d valid=%b ready=%b err=%b, want data=%0d valid=%b ready=%b err=%b",
               name, out_data4, out_valid4, in_ready4, sel_err4, d, v, r, e);
    end
  endtask

  task automatic test_reset();
    bus4 = {32'd400, 32'd300, 32'd200, 32'd100};
    in_valid4 = 1'b1; sel4 = 2'd1; out_ready4 = 1'b0;
    step();
    in_valid4 = 1'b0;
    chk4("pre_reset_load", 32'd200, 1'b1, 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid4 !== 1'b0 || out_data4 !== 32'd0 || in_ready4 !== 1'b1 || sel_err4 !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got data=%0d valid=%b ready=%b err=%b, want 0/0/1/0",
               out_data4, out_valid4, in_ready4, sel_err4);
    end
    vectors++;
    if (out_valid3 !== 1'b0 || out_data3 !== 32'd0 || in_ready3 !== 1'b1 || sel_err3 !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset3: got data=%0d valid=%b ready=%b err=%b, want 0/0/1/0",
               out_data3, out_valid3, in_ready3, sel_err3);
    end
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    bus4 = {32'd400, 32'd300, 32'd200, 32'd100};
    out_ready4 = 1'b1;
    in_valid4 = 1'b1; sel4 = 2'd0;
    step();
    chk4("b2b_word0", 32'd100, 1'b1, 1'b1, 1'b0);
    sel4 = 2'd1;
    step();
    chk4("b2b_word1", 32'd200, 1'b1, 1'b1, 1'b0);
    in_valid4 = 1'b0;
    step();
    chk4("b2b_drain", 32'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic fill_full2();
    bus4 = {32'd400, 32'd300, 32'd200, 32'd100};
    out_ready4 = 1'b0;
    in_valid4 = 1'b1; sel4 = 2'd2;
    step();
    chk4("bp_first", 32'd300, 1'b1, 1'b1, 1'b0);
    sel4 = 2'd3;
    step();
    in_valid4 = 1'b0;
    chk4("bp_full2", 32'd300, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    fill_full2();
    step();
    chk4("bp_hold", 32'd300, 1'b1, 1'b0, 1'b0);
    out_ready4 = 1'b1;
    step();
    chk4("bp_release", 32'd400, 1'b1, 1'b1, 1'b0);
    step();
    chk4("bp_empty", 32'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_sel_range();
    bus3 = {32'd2, 32'd1, 32'hDEADBEEF};
    out_ready3 = 1'b1;
    in_valid3 = 1'b1; sel3 = 2'd3;
    step();
    in_valid3 = 1'b0;
    vectors++;
    if (out_data3 !== 32'hDEADBEEF || out_valid3 !== 1'b1 || sel_err3 !== 1'b1) begin
      miscompares++;
      $display("FAIL sel_oob: got data=%h valid=%b err=%b, want deadbeef/1/1",
               out_data3, out_valid3, sel_err3);
    end
    step();
    vectors++;
    if (sel_err3 !== 1'b0 || out_valid3 !== 1'b0) begin
      miscompares++;
      $display("FAIL sel_err_pulse: got err=%b valid=%b, want 0/0", sel_err3, out_valid3);
    end
    in_valid3 = 1'b1; sel3 = 2'd2;
    step();
    in_valid3 = 1'b0;
    vectors++;
    if (out_data3 !== 32'd2 || out_valid3 !== 1'b1 || sel_err3 !== 1'b0) begin
      miscompares++;
      $display("FAIL sel_top: got data=%0d valid=%b err=%b, want 2/1/0", out_data3, out_valid3, sel_err3);
    end
    step();
  endtask

  task automatic test_flush();
    fill_full2();
    flush = 1'b1; in_valid4 = 1'b1; sel4 = 2'd0;
    step();
    flush = 1'b0; in_valid4 = 1'b0;
    chk4("flush_full2", 32'd0, 1'b0, 1'b1, 1'b0);
    step();
    chk4("flush_no_leak", 32'd0, 1'b0, 1'b1, 1'b0);
    // Flush on an edge where an out-of-range word is accepted into an empty buffer
    out_ready3 = 1'b0;
    flush = 1'b1; in_valid3 = 1'b1; sel3 = 2'd3;
    step();
    flush = 1'b0; in_valid3 = 1'b0;
    vectors++;
    if (out_valid3 !== 1'b0 || sel_err3 !== 1'b0 || in_ready3 !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_accept: got valid=%b err=%b ready=%b, want 0/0/1", out_valid3, sel_err3, in_ready3);
    end
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] wds[4];
    logic [31:0] exp;
    int got = 0;
    int cycles = 0;
    while (got < 300 && cycles < 5000) begin
      for (int i = 0; i < 4; i++) wds[i] = $urandom;
      bus4 = {wds[3], wds[2], wds[1], wds[0]};
      sel4 = 2'($urandom_range(0, 3));
      in_valid4 = ($urandom_range(0, 3) != 0);
      out_ready4 = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      vectors++;
      if (out_valid4 !== (q.size() > 0) || in_ready4 !== (q.size() < 2)) begin
        miscompares++;
        $display("FAIL rand_flags: got valid=%b ready=%b, want occupancy %0d", out_valid4, in_ready4, q.size());
      end
      if (out_valid4 && out_ready4) begin
        exp = (q.size() > 0) ? q.pop_front() : 32'hx;
        vectors++;
        if (out_data4 !== exp) begin
          miscompares++;
          $display("FAIL rand_data: transfer %0d got %h want %h", got, out_data4, exp);
        end
        got++;
      end
      if (in_valid4 && in_ready4) q.push_back(wds[sel4]);
      step();
      cycles++;
    end
    in_valid4 = 1'b0;
    vectors++;
    if (got < 300) begin
      miscompares++;
      $display("FAIL rand_timeout: got %0d transfers want 300", got);
    end
    out_ready4 = 1'b1;
    step(); step(); step();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    bus4 = '0; sel4 = '0; in_valid4 = 1'b0; out_ready4 = 1'b0;
    bus3 = '0; sel3 = '0; in_valid3 = 1'b0; out_ready3 = 1'b0;
    #12 rst_n = 1'b1;
    step();
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_sel_range();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
